// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller.
// Owns the PC, captures the fetched word into a one-entry fetch/decode
// register, resolves PC-relative j in fetch, takes execute redirects,
// honours decode stalls and raises precise fetch exceptions.
`timescale 1ns/1ps
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter logic [31:0] EXC_VECTOR = 32'd128
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instruction,
    input  logic        fs_stall,
    input  logic        fs_redirect,
    input  logic [31:0] fs_redirect_pc,
    output logic [31:0] fs_instr,
    output logic [31:0] fs_instr_pc,
    output logic        fs_valid,
    output logic        fs_exc,
    output logic [31:0] fs_epc,
    output logic [1:0]  fs_cause,
    output logic        fs_halted
);

    localparam int unsigned XLEN     = 32;
    localparam int unsigned OP_W     = 6;
    localparam int unsigned JIMM_W   = 26;
    localparam int unsigned CAUSE_W  = 2;

    localparam logic [OP_W-1:0]    OP_J       = 6'b000010;
    localparam logic [OP_W-1:0]    OP_ILLEGAL = 6'b111111;
    localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL  = 2'd1;
    localparam logic [CAUSE_W-1:0] CAUSE_MISALIGN = 2'd2;
    localparam logic [XLEN-1:0]    PC_STEP    = 32'd4;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_EXC,
        S_HALT
    } state_t;

    state_t            state, state_nxt;
    logic [XLEN-1:0]   imem_pc_nxt;
    logic [XLEN-1:0]   fs_instr_nxt;
    logic [XLEN-1:0]   fs_instr_pc_nxt;
    logic              fs_valid_nxt;
    logic              fs_exc_nxt;
    logic [XLEN-1:0]   fs_epc_nxt;
    logic [CAUSE_W-1:0] fs_cause_nxt;
    logic              fs_halted_nxt;

    logic [OP_W-1:0]   opcode;
    logic              misaligned;
    logic              illegal;
    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   jump_offset;
    logic [XLEN-1:0]   jump_target;

    // Decode of the word currently on the memory bus and candidate next PCs.
    always_comb begin
        opcode      = imem_instruction[31:26];
        misaligned  = (imem_pc[1:0] != 2'b00);
        illegal     = (opcode == OP_ILLEGAL);
        pc_plus4    = XLEN'(imem_pc + PC_STEP);
        jump_offset = {{(XLEN-JIMM_W-2){imem_instruction[JIMM_W-1]}},
                       imem_instruction[JIMM_W-1:0], 2'b00};
        jump_target = XLEN'(pc_plus4 + jump_offset);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt       = state;
        imem_pc_nxt     = imem_pc;
        fs_instr_nxt    = fs_instr;
        fs_instr_pc_nxt = fs_instr_pc;
        fs_valid_nxt    = fs_valid;
        fs_exc_nxt      = 1'b0;
        fs_epc_nxt      = fs_epc;
        fs_cause_nxt    = fs_cause;
        fs_halted_nxt   = fs_halted;

        unique case (state)
            // BOOT and EXC each issue one bubble; a redirect still steers the PC.
            S_BOOT, S_EXC: begin
                fs_valid_nxt = 1'b0;
                state_nxt    = S_RUN;
                if (fs_redirect) begin
                    imem_pc_nxt = fs_redirect_pc;
                end
            end

            S_RUN: begin
                if (fs_redirect) begin
                    // In-flight fetch is dropped regardless of stall.
                    imem_pc_nxt  = fs_redirect_pc;
                    fs_valid_nxt = 1'b0;
                end else if (misaligned || illegal) begin
                    fs_exc_nxt   = 1'b1;
                    fs_epc_nxt   = imem_pc;
                    fs_cause_nxt = misaligned ? CAUSE_MISALIGN : CAUSE_ILLEGAL;
                    fs_valid_nxt = 1'b0;
                    // Faulting in the handler itself is unrecoverable.
                    if (imem_pc == EXC_VECTOR) begin
                        state_nxt     = S_HALT;
                        fs_halted_nxt = 1'b1;
                    end else begin
                        state_nxt   = S_EXC;
                        imem_pc_nxt = EXC_VECTOR;
                    end
                end else if (!fs_stall) begin
                    fs_instr_nxt    = imem_instruction;
                    fs_instr_pc_nxt = imem_pc;
                    fs_valid_nxt    = 1'b1;
                    imem_pc_nxt     = (opcode == OP_J) ? jump_target : pc_plus4;
                end
            end

            S_HALT: begin
                fs_valid_nxt = 1'b0;
            end

            default: begin
                state_nxt = S_BOOT;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_BOOT;
            imem_pc     <= RESET_PC;
            fs_instr    <= '0;
            fs_instr_pc <= '0;
            fs_valid    <= 1'b0;
            fs_exc      <= 1'b0;
            fs_epc      <= '0;
            fs_cause    <= '0;
            fs_halted   <= 1'b0;
        end else begin
            state       <= state_nxt;
            imem_pc     <= imem_pc_nxt;
            fs_instr    <= fs_instr_nxt;
            fs_instr_pc <= fs_instr_pc_nxt;
            fs_valid    <= fs_valid_nxt;
            fs_exc      <= fs_exc_nxt;
            fs_epc      <= fs_epc_nxt;
            fs_cause    <= fs_cause_nxt;
            fs_halted   <= fs_halted_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: behavioural reference model compared every
// cycle, plus literal checks at the notable points of the directed scenario.
`timescale 1ns/1ps
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic [31:0] imem_pc;
    logic [31:0] imem_instruction;
    logic        fs_stall;
    logic        fs_redirect;
    logic [31:0] fs_redirect_pc;
    logic [31:0] fs_instr;
    logic [31:0] fs_instr_pc;
    logic        fs_valid;
    logic        fs_exc;
    logic [31:0] fs_epc;
    logic [1:0]  fs_cause;
    logic        fs_halted;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .imem_pc          (imem_pc),
        .imem_instruction (imem_instruction),
        .fs_stall         (fs_stall),
        .fs_redirect      (fs_redirect),
        .fs_redirect_pc   (fs_redirect_pc),
        .fs_instr         (fs_instr),
        .fs_instr_pc      (fs_instr_pc),
        .fs_valid         (fs_valid),
        .fs_exc           (fs_exc),
        .fs_epc           (fs_epc),
        .fs_cause         (fs_cause),
        .fs_halted        (fs_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: sparse overrides, otherwise an addi-type word.
    logic [31:0] mem [bit [31:0]];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] k;
        k = {a[31:2], 2'b00};
        if (mem.exists(k)) return mem[k];
        return {6'b001000, k[25:0]};
    endfunction

    always @(imem_pc) imem_instruction = mem_word(imem_pc);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: mode 0 boot, 1 run, 2 exception bubble, 3 halted.
    int          m_mode;
    logic [31:0] m_pc, m_instr, m_ipc, m_epc;
    logic        m_valid, m_exc, m_halt;
    logic [1:0]  m_cause;

    always @(posedge clk or negedge reset) begin
        logic [31:0] w;
        longint      off;
        if (!reset) begin
            m_mode = 0; m_pc = 32'd0; m_instr = 0; m_ipc = 0; m_epc = 0;
            m_valid = 0; m_exc = 0; m_halt = 0; m_cause = 0;
        end else begin
            m_exc = 0;
            if (m_mode == 0 || m_mode == 2) begin
                m_valid = 0;
                if (fs_redirect) m_pc = fs_redirect_pc;
                m_mode = 1;
            end else if (m_mode == 3) begin
                m_valid = 0;
            end else begin
                w = mem_word(m_pc);
                if (fs_redirect) begin
                    m_pc = fs_redirect_pc;
                    m_valid = 0;
                end else if (m_pc % 4 != 0 || w[31:26] == 6'd63) begin
                    m_epc   = m_pc;
                    m_cause = (m_pc % 4 != 0) ? 2'd2 : 2'd1;
                    m_exc   = 1;
                    m_valid = 0;
                    if (m_pc == 32'd128) begin
                        m_mode = 3; m_halt = 1;
                    end else begin
                        m_mode = 2; m_pc = 32'd128;
                    end
                end else if (!fs_stall) begin
                    m_instr = w; m_ipc = m_pc; m_valid = 1;
                    if (w[31:26] == 6'd2) begin
                        off = longint'(w[25:0]);
                        if (off >= 64'sd33554432) off -= 64'sd67108864;
                        m_pc = 32'(longint'(m_pc) + 4 + off * 4);
                    end else begin
                        m_pc = 32'(longint'(m_pc) + 4);
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            chk("imem_pc",     imem_pc,            m_pc);
            chk("fs_instr",    fs_instr,           m_instr);
            chk("fs_instr_pc", fs_instr_pc,        m_ipc);
            chk("fs_valid",    32'(fs_valid),      32'(m_valid));
            chk("fs_exc",      32'(fs_exc),        32'(m_exc));
            chk("fs_epc",      fs_epc,             m_epc);
            chk("fs_cause",    32'(fs_cause),      32'(m_cause));
            chk("fs_halted",   32'(fs_halted),     32'(m_halt));
        end
    end

    task automatic step(input bit s, input bit r, input logic [31:0] rpc);
        fs_stall       = s;
        fs_redirect    = r;
        fs_redirect_pc = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"},    imem_pc, 32'd0);
        chk({tag, "_instr"}, fs_instr, 32'd0);
        chk({tag, "_ipc"},   fs_instr_pc, 32'd0);
        chk({tag, "_valid"}, 32'(fs_valid), 32'd0);
        chk({tag, "_exc"},   32'(fs_exc), 32'd0);
        chk({tag, "_epc"},   fs_epc, 32'd0);
        chk({tag, "_cause"}, 32'(fs_cause), 32'd0);
        chk({tag, "_halt"},  32'(fs_halted), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        fs_stall = 1'b0; fs_redirect = 1'b0; fs_redirect_pc = 32'd0;
        mem[32'd36] = 32'h0BFFFFF6;
        #12;
        chk_reset_vals("rst0");
        @(negedge clk);
        reset = 1'b1;

        // Sequential fetch from reset.
        step(0, 0, 0);
        chk("boot_valid", 32'(fs_valid), 32'd0);
        chk("boot_pc", imem_pc, 32'd0);
        step(0, 0, 0);
        chk("seq1_valid", 32'(fs_valid), 32'd1);
        chk("seq1_ipc", fs_instr_pc, 32'd0);
        chk("seq1_pc", imem_pc, 32'd4);
        step(0, 0, 0);
        chk("seq2_ipc", fs_instr_pc, 32'd4);
        chk("seq2_pc", imem_pc, 32'd8);
        repeat (7) step(0, 0, 0);
        chk("seq_pc36", imem_pc, 32'd36);

        // Jump back to 0 with no bubble.
        step(0, 0, 0);
        chk("j_pc", imem_pc, 32'd0);
        chk("j_instr", fs_instr, 32'h0BFFFFF6);
        chk("j_ipc", fs_instr_pc, 32'd36);
        chk("j_valid", 32'(fs_valid), 32'd1);

        // Stall at 48, then redirect to 40 coincident with stall.
        step(0, 1, 32'd44);
        chk("redir44_valid", 32'(fs_valid), 32'd0);
        step(0, 0, 0);
        chk("pc48", imem_pc, 32'd48);
        repeat (3) begin
            step(1, 0, 0);
            chk("stall_pc", imem_pc, 32'd48);
            chk("stall_ipc", fs_instr_pc, 32'd44);
        end
        step(1, 1, 32'd40);
        chk("redir40_pc", imem_pc, 32'd40);
        chk("redir40_valid", 32'(fs_valid), 32'd0);
        step(0, 0, 0);
        chk("after_redir_valid", 32'(fs_valid), 32'd1);
        chk("after_redir_ipc", fs_instr_pc, 32'd40);

        // Illegal opcode at 48.
        mem[32'd48] = 32'hFC000000;
        step(0, 0, 0);
        step(0, 0, 0);
        chk("ill_exc", 32'(fs_exc), 32'd1);
        chk("ill_epc", fs_epc, 32'd48);
        chk("ill_cause", 32'(fs_cause), 32'd1);
        chk("ill_pc", imem_pc, 32'd128);
        chk("ill_valid", 32'(fs_valid), 32'd0);
        step(1, 0, 0);
        chk("exc_pulse_end", 32'(fs_exc), 32'd0);
        chk("exc_bubble2", 32'(fs_valid), 32'd0);
        step(0, 0, 0);
        chk("vec_valid", 32'(fs_valid), 32'd1);
        chk("vec_ipc", fs_instr_pc, 32'd128);

        // PC wrap past the top of the address space.
        step(0, 1, 32'hFFFFFFFC);
        step(0, 0, 0);
        chk("wrap_pc", imem_pc, 32'd0);
        chk("wrap_ipc", fs_instr_pc, 32'hFFFFFFFC);

        // Misaligned redirect, then fault inside the handler -> halt.
        mem[32'd128] = 32'hFC000000;
        step(0, 1, 32'd6);
        step(0, 0, 0);
        chk("mis_cause", 32'(fs_cause), 32'd2);
        chk("mis_epc", fs_epc, 32'd6);
        chk("mis_exc", 32'(fs_exc), 32'd1);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("halt_flag", 32'(fs_halted), 32'd1);
        chk("halt_epc", fs_epc, 32'd128);
        chk("halt_exc", 32'(fs_exc), 32'd1);
        step(0, 1, 32'd0);
        chk("halt_pc_frozen", imem_pc, 32'd128);
        chk("halt_valid", 32'(fs_valid), 32'd0);

        // Reset out of halt, restart, then reset mid-stream at PC 20.
        #2 reset = 1'b0;
        #1 chk_reset_vals("rst_halt");
        mem.delete(32'd128);
        @(negedge clk);
        reset = 1'b1;
        step(0, 0, 0);
        step(0, 0, 0);
        chk("restart_valid", 32'(fs_valid), 32'd1);
        chk("restart_ipc", fs_instr_pc, 32'd0);
        repeat (4) step(0, 0, 0);
        chk("pc20", imem_pc, 32'd20);
        #2 reset = 1'b0;
        #1 chk_reset_vals("rst_mid");
        @(negedge clk);
        reset = 1'b1;

        // Redirect honoured during BOOT.
        step(0, 1, 32'd8);
        chk("boot_redir_pc", imem_pc, 32'd8);
        chk("boot_redir_valid", 32'(fs_valid), 32'd0);
        step(0, 0, 0);
        chk("boot_redir_ipc", fs_instr_pc, 32'd8);

        // Random stalls over j, illegal and vector paths; model-checked.
        repeat (40) step($urandom_range(0, 3) == 0, 0, 0);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
